fetch_controller: RTL and testbench
===================================

FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 Parameter MEM_WORDS, default 256: number of instruction-memory words; legal fetch addresses are 0..MEM_WORDS-1.
REQ-002 Parameter RESET_PC, default 0: word address loaded into the PC at reset.
REQ-003 Parameter FIFO_DEPTH, default 2: number of entries in the fetch buffer; legal values are 2 and 4.
REQ-004 clk  in  1  single clock; all state changes on the rising edge.
REQ-005 rst_n  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-006 start  in  1  level; begins or resumes fetching from IDLE or HALT.
REQ-007 halt_req  in  1  level; stops issuing new fetches while in RUN.
REQ-008 redirect_valid  in  1  branch/jump redirect strobe, one cycle.
REQ-009 redirect_pc  in  32  word address of the redirect target.
REQ-010 imem_addr  out  32  word address driven to the combinational instruction memory; equals the PC.
REQ-011 imem_data  in  32  instruction word returned combinationally for imem_addr.
REQ-012 inst_valid  out  1  the FIFO head holds a valid instruction.
REQ-013 inst_ready  in  1  the decode stage accepts the head entry.
REQ-014 inst_out  out  32  instruction word at the FIFO head.
REQ-015 inst_pc  out  32  word address of the FIFO head entry.
REQ-016 busy  out  1  high in RUN.
REQ-017 fault  out  1  sticky; high in FAULT.
REQ-018 fetch_count  out  32  number of enqueued fetches since reset; wraps at 2^32.

Function
REQ-019 FSM states and encoding: IDLE(0), RUN(1), HALT(2), FAULT(3).
REQ-020 Transitions:
- IDLE -> RUN on start.
- RUN -> HALT on halt_req.
- HALT -> RUN on start with halt_req low.
- RUN -> FAULT when an enqueue would occur and pc >= MEM_WORDS.
- FAULT exits only on reset.
REQ-021 Fetch condition: state==RUN, halt_req low, redirect_valid low, pc < MEM_WORDS, and (FIFO not full, or pop occurs this cycle).
REQ-022 On fetch, {pc, imem_data} is written to the FIFO tail, pc <= pc+1 (32-bit wrap), and fetch_count increments, all at the same edge; fetch latency is 0 (the memory is combinational).
REQ-023 Pop occurs when inst_valid && inst_ready; the head advances at the edge. A full FIFO with a pop and a fetch in the same cycle keeps the same occupancy.
REQ-024 inst_out and inst_pc are valid only while inst_valid is high and are held stable while inst_valid && !inst_ready.
REQ-025 Redirect, accepted in RUN, HALT and IDLE and ignored in FAULT, flushes the FIFO, sets pc <= redirect_pc and suppresses both fetch and pop that cycle; inst_valid is 0 on the next cycle.
REQ-026 Redirect has priority over halt_req, pop and fetch; halt_req has priority over start.
REQ-027 In HALT and FAULT no fetch occurs, and the FIFO drains normally through pops.
REQ-028 The out-of-range check applies to the current pc only; a redirect to an out-of-range target faults on the first fetch attempt after it.
REQ-029 imem_addr = pc continuously, in every state.

Reset
REQ-030 While rst_n==0 at a clock edge:
- state <= IDLE and pc <= RESET_PC;
- the FIFO is emptied (inst_valid=0);
- fetch_count <= 0, fault <= 0, busy <= 0;
- inst_out and inst_pc <= 0.
REQ-031 Reset in mid-operation discards all FIFO entries and any pending redirect with no partial effects; inputs are ignored in the reset cycle.

Structure
REQ-032 Shared package fetch_pkg holds:
- the state encoding constants;
- the FIFO entry width (64 = pc + instruction);
- the RESET_PC default.
REQ-033 The FIFO is a separate sub-module fetch_fifo with:
- push, pop and flush inputs;
- full, empty, head outputs;
- flush taking priority over push and pop.

Verification
REQ-034 Reset, then start=1, inst_ready=1 -> inst_pc sequence 0,1,2,3 on consecutive cycles; first inst_valid one cycle after start; fetch_count=4 after 4 fetches.
REQ-035 inst_ready=0 for 5 cycles in RUN -> FIFO fills to FIFO_DEPTH; fetch stops; pc holds at RESET_PC+FIFO_DEPTH; the head stays pc 0 unchanged.
REQ-036 redirect_valid=1, redirect_pc=0x40 with a full FIFO -> next cycle inst_valid=0; the following cycle inst_pc=0x40, then 0x41.
REQ-037 redirect_pc=0xFE with MEM_WORDS=256 -> fetches at 0xFE and 0xFF, then fault=1 and busy=0; the FIFO drains both entries; start is then ignored.
REQ-038 halt_req=1 for 3 cycles, then start=1 -> no fetch and pc frozen during halt; fetching resumes at the frozen pc with no gaps or duplicates.
REQ-039 rst_n=0 asserted for one cycle with the FIFO holding 2 entries and redirect_valid=1 -> next cycle inst_valid=0, pc=RESET_PC, state IDLE, fetch_count=0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
package fetch_pkg;

  // Controller states; the encoding is visible to debug tooling.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_HALT  = 2'd2,
    ST_FAULT = 2'd3
  } fetch_state_t;

  // One buffered fetch: word address in the upper half, instruction in the lower half.
  localparam int ENTRY_W = 64;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'd0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  // Bundle a fetch address and its instruction into one buffer entry.
  function automatic fetch_entry_t make_entry(input logic [31:0] pc, input logic [31:0] inst);
    fetch_entry_t e;
    e.pc   = pc;
    e.inst = inst;
    return e;
  endfunction

endpackage

// File: rtl/fetch_controller_if.sv
// Memory, decode-handshake and redirect signals between the fetch controller and its neighbours.
interface fetch_controller_if;

  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  // Fetch controller side.
  modport master (
    output imem_addr,
    output inst_valid,
    output inst_out,
    output inst_pc,
    input  imem_data,
    input  inst_ready,
    input  redirect_valid,
    input  redirect_pc
  );

  // Memory / decode / branch-unit side.
  modport slave (
    input  imem_addr,
    input  inst_valid,
    input  inst_out,
    input  inst_pc,
    output imem_data,
    output inst_ready,
    output redirect_valid,
    output redirect_pc
  );

endinterface

// File: rtl/fetch_fifo.sv
// Small shift-register fetch buffer. The head always sits in entry 0, so the
// head output comes straight from a flop. Flush wins over push and pop.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  logic               pop,
  input  logic               flush,
  input  logic [ENTRY_W-1:0] push_data,
  output logic               full,
  output logic               empty,
  output logic [ENTRY_W-1:0] head
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [ENTRY_W-1:0] mem_r     [DEPTH];
  logic [ENTRY_W-1:0] mem_nxt_s [DEPTH];
  logic [CW-1:0]      count_r;
  logic [CW-1:0]      count_nxt_s;
  logic [CW-1:0]      wr_idx_s;
  logic               push_eff_s;
  logic               pop_eff_s;

  assign full  = (count_r == CNT_FULL);
  assign empty = (count_r == CNT_ZERO);
  assign head  = mem_r[0];

  // Ignore pops of an empty buffer and pushes into a full one that is not also popping.
  always_comb begin
    pop_eff_s  = pop && !empty;
    push_eff_s = push && (!full || pop_eff_s);
  end

  // Next buffer contents: shift down on pop, then write the tail slot on push.
  always_comb begin
    mem_nxt_s   = mem_r;
    count_nxt_s = count_r;
    wr_idx_s    = count_r;
    if (flush) begin
      count_nxt_s = CNT_ZERO;
    end else begin
      if (pop_eff_s) begin
        for (int i = 0; i < DEPTH - 1; i++) begin
          mem_nxt_s[i] = mem_r[i + 1];
        end
        wr_idx_s = count_r - CNT_ONE;
      end else begin
        wr_idx_s = count_r;
      end
      if (push_eff_s) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (CW'(i) == wr_idx_s) begin
            mem_nxt_s[i] = push_data;
          end else begin
            mem_nxt_s[i] = mem_nxt_s[i];
          end
        end
      end else begin
        mem_nxt_s = mem_nxt_s;
      end
      case ({push_eff_s, pop_eff_s})
        2'b10:   count_nxt_s = count_r + CNT_ONE;
        2'b01:   count_nxt_s = count_r - CNT_ONE;
        default: count_nxt_s = count_r;
      endcase
    end
  end

  // Buffer storage and occupancy; reset clears the contents so the head reads zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_r <= CNT_ZERO;
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {ENTRY_W{1'b0}};
      end
    end else begin
      count_r <= count_nxt_s;
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= mem_nxt_s[i];
      end
    end
  end

endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch controller: walks the PC through a combinational
// instruction memory, buffers {pc, instruction} pairs for decode, and
// handles start/halt, redirects and out-of-range faults.
module fetch_controller
  import fetch_pkg::*;
#(
  parameter int          MEM_WORDS  = 256,
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      halt_req,
  fetch_controller_if.master        bus,
  output logic                      busy,
  output logic                      fault,
  output logic [31:0]               fetch_count
);

  localparam logic [31:0] MEM_LIMIT = 32'(MEM_WORDS);

  fetch_state_t       state_r;
  fetch_state_t       state_nxt_s;
  logic [31:0]        pc_r;
  logic [31:0]        fetch_count_r;
  logic               busy_r;
  logic               fault_r;

  logic               redirect_s;
  logic               pop_s;
  logic               attempt_s;
  logic               in_range_s;
  logic               fetch_s;

  logic               fifo_full_s;
  logic               fifo_empty_s;
  logic [ENTRY_W-1:0] fifo_head_s;
  fetch_entry_t       head_entry_s;
  fetch_entry_t       push_entry_s;

  // Per-cycle strobes. A redirect outside FAULT flushes and blocks pop/fetch;
  // any redirect_valid (even one ignored in FAULT) blocks a fetch attempt.
  always_comb begin
    redirect_s = bus.redirect_valid && (state_r != ST_FAULT);
    pop_s      = !fifo_empty_s && bus.inst_ready && !redirect_s;
    attempt_s  = (state_r == ST_RUN) && !halt_req && !bus.redirect_valid &&
                 (!fifo_full_s || pop_s);
    in_range_s = (pc_r < MEM_LIMIT);
    fetch_s    = attempt_s && in_range_s;
  end

  // State transitions. Start together with halt_req does not leave IDLE or HALT;
  // a redirect in RUN defers both halting and faulting by a cycle.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start && !halt_req) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (bus.redirect_valid) begin
          state_nxt_s = ST_RUN;
        end else if (halt_req) begin
          state_nxt_s = ST_HALT;
        end else if (attempt_s && !in_range_s) begin
          state_nxt_s = ST_FAULT;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_HALT: begin
        if (start && !halt_req) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_HALT;
        end
      end
      ST_FAULT: state_nxt_s = ST_FAULT;
      default:  state_nxt_s = ST_IDLE;
    endcase
  end

  // State register plus flopped status outputs derived from the next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
      fault_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s == ST_RUN);
      fault_r <= (state_nxt_s == ST_FAULT);
    end
  end

  // PC and fetch counter: redirect loads the target, a fetch advances by one word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_r          <= RESET_PC;
      fetch_count_r <= 32'd0;
    end else if (redirect_s) begin
      pc_r          <= bus.redirect_pc;
      fetch_count_r <= fetch_count_r;
    end else if (fetch_s) begin
      pc_r          <= pc_r + 32'd1;
      fetch_count_r <= fetch_count_r + 32'd1;
    end else begin
      pc_r          <= pc_r;
      fetch_count_r <= fetch_count_r;
    end
  end

  assign push_entry_s = make_entry(pc_r, bus.imem_data);

  fetch_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (fetch_s),
    .pop      (pop_s),
    .flush    (redirect_s),
    .push_data(push_entry_s),
    .full     (fifo_full_s),
    .empty    (fifo_empty_s),
    .head     (fifo_head_s)
  );

  assign head_entry_s   = fetch_entry_t'(fifo_head_s);
  assign bus.imem_addr  = pc_r;
  assign bus.inst_valid = !fifo_empty_s;
  assign bus.inst_out   = head_entry_s.inst;
  assign bus.inst_pc    = head_entry_s.pc;
  assign busy           = busy_r;
  assign fault          = fault_r;
  assign fetch_count    = fetch_count_r;

endmodule

// File: tb/tb_fetch_controller.sv
// Self-checking bench for fetch_controller: directed scenarios plus a
// randomized run compared against a queue-based reference model.
module tb_fetch_controller;

  localparam int          MEM_WORDS = 256;
  localparam int          DEPTH     = 2;
  localparam logic [31:0] RST_PC    = 32'd0;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_HALT  = 2;
  localparam int M_FAULT = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        halt_req;
  logic        busy;
  logic        fault;
  logic [31:0] fetch_count;

  fetch_controller_if bus ();

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int          m_mode;
  logic [31:0] m_pc;
  logic [31:0] m_count;
  logic [63:0] m_q[$];

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction

  assign bus.imem_data = mem_word(bus.imem_addr);

  fetch_controller #(
    .MEM_WORDS (MEM_WORDS),
    .RESET_PC  (RST_PC),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .halt_req   (halt_req),
    .bus        (bus),
    .busy       (busy),
    .fault      (fault),
    .fetch_count(fetch_count)
  );

  // Advance the reference model by one clock edge using the inputs now applied.
  task automatic model_edge();
    bit redir, pop, attempt, fetch;
    int nm;
    if (!rst_n) begin
      m_mode  = M_IDLE;
      m_pc    = RST_PC;
      m_count = 32'd0;
      m_q.delete();
      return;
    end
    redir   = bus.redirect_valid && (m_mode != M_FAULT);
    pop     = (m_q.size() > 0) && bus.inst_ready && !redir;
    attempt = (m_mode == M_RUN) && !halt_req && !bus.redirect_valid &&
              ((m_q.size() < DEPTH) || pop);
    fetch   = attempt && (m_pc < 32'(MEM_WORDS));
    nm = m_mode;
    if ((m_mode == M_IDLE || m_mode == M_HALT) && start && !halt_req) nm = M_RUN;
    if (m_mode == M_RUN && !bus.redirect_valid) begin
      if (halt_req) nm = M_HALT;
      else if (attempt && m_pc >= 32'(MEM_WORDS)) nm = M_FAULT;
    end
    if (redir) begin
      m_q.delete();
      m_pc = bus.redirect_pc;
    end else begin
      if (pop) void'(m_q.pop_front());
      if (fetch) begin
        m_q.push_back({m_pc, mem_word(m_pc)});
        m_pc    = m_pc + 32'd1;
        m_count = m_count + 32'd1;
      end
    end
    m_mode = nm;
  endtask

  // Apply inputs mid-cycle, clock once, update the model, sample just after the edge.
  task automatic tick(input logic rn, input logic st, input logic hr,
                      input logic rv, input logic [31:0] rp, input logic rdy);
    rst_n              = rn;
    start              = st;
    halt_req           = hr;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rp;
    bus.inst_ready     = rdy;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    tick(1'b0, 1'b1, 1'b0, 1'b1, 32'h55, 1'b1);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    checks++; if (bus.inst_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %0b want 0", bus.inst_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %0b want 0", busy); end
    checks++; if (fault !== 1'b0) begin failures++; $display("FAIL reset_fault: got %0b want 0", fault); end
    checks++; if (fetch_count !== 32'd0) begin failures++; $display("FAIL reset_count: got %0h want 0", fetch_count); end
    checks++; if (bus.imem_addr !== RST_PC) begin failures++; $display("FAIL reset_pc: got %0h want %0h", bus.imem_addr, RST_PC); end
    checks++; if (bus.inst_out !== 32'd0) begin failures++; $display("FAIL reset_inst_out: got %0h want 0", bus.inst_out); end
    checks++; if (bus.inst_pc !== 32'd0) begin failures++; $display("FAIL reset_inst_pc: got %0h want 0", bus.inst_pc); end
  endtask

  task automatic test_sequential_fetch();
    tick(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    tick(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    checks++; if (bus.inst_valid !== 1'b0) begin failures++; $display("FAIL seq_first_valid: got %0b want 0", bus.inst_valid); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL seq_busy: got %0b want 1", busy); end
    for (int k = 0; k < 4; k++) begin
      tick(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
      checks++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== RST_PC + 32'(k)) begin
        failures++; $display("FAIL seq_pc%0d: got valid=%0b pc=%0h want valid=1 pc=%0h", k, bus.inst_valid, bus.inst_pc, RST_PC + 32'(k));
      end
      checks++; if (bus.inst_out !== mem_word(RST_PC + 32'(k))) begin
        failures++; $display("FAIL seq_inst%0d: got %0h want %0h", k, bus.inst_out, mem_word(RST_PC + 32'(k)));
      end
    end
    checks++; if (fetch_count !== 32'd4) begin failures++; $display("FAIL seq_count: got %0d want 4", fetch_count); end
  endtask

  task automatic test_backpressure();
    tick(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    tick(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    for (int k = 0; k < 5; k++) tick(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    checks++; if (bus.imem_addr !== RST_PC + 32'(DEPTH)) begin failures++; $display("FAIL bp_pc: got %0h want %0h", bus.imem_addr, RST_PC + 32'(DEPTH)); end
    checks++; if (fetch_count !== 32'(DEPTH)) begin failures++; $display("FAIL bp_count: got %0d want %0d", fetch_count, DEPTH); end
    checks++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== RST_PC) begin failures++; $display("FAIL bp_head: got valid=%0b pc=%0h want valid=1 pc=%0h", bus.inst_valid, bus.inst_pc, RST_PC); end
    checks++; if (bus.inst_out !== mem_word(RST_PC)) begin failures++; $display("FAIL bp_inst: got %0h want %0h", bus.inst_out, mem_word(RST_PC)); end
  endtask

  // Runs on the full buffer left by test_backpressure.
  task automatic test_redirect();
    tick(1'b1, 1'b1, 1'b0, 1'b1, 32'h40, 1'b0);
    checks++; if (bus.inst_valid !== 1'b0) begin failures++; $display("FAIL redir_flush: got valid=%0b want 0", bus.inst_valid); end
    checks++; if (bus.imem_addr !== 32'h40) begin failures++; $display("FAIL redir_pc: got %0h want 40", bus.imem_addr); end
    tick(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    checks++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h40) begin failures++; $display("FAIL redir_first: got valid=%0b pc=%0h want valid=1 pc=40", bus.inst_valid, bus.inst_pc); end
    tick(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    checks++; if (bus.inst_pc !== 32'h41) begin failures++; $display("FAIL redir_second: got %0h want 41", bus.inst_pc); end
  endtask

  task automatic test_fault();
    logic [31:0] fc0;
    tick(1'b1, 1'b1, 1'b0, 1'b1, 32'hFE, 1'b0);
    fc0 = fetch_count;
    tick(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    tick(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    checks++; if (fault !== 1'b0 || bus.inst_pc !== 32'hFE || fetch_count !== fc0 + 32'd2) begin
      failures++; $display("FAIL fault_prefetch: got fault=%0b pc=%0h count=%0d want 0/fe/%0d", fault, bus.inst_pc, fetch_count, fc0 + 32'd2);
    end
    tick(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    checks++; if (fault !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL fault_enter: got fault=%0b busy=%0b want 1/0", fault, busy); end
    checks++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'hFF) begin failures++; $display("FAIL fault_drain1: got valid=%0b pc=%0h want 1/ff", bus.inst_valid, bus.inst_pc); end
    tick(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    checks++; if (bus.inst_valid !== 1'b0) begin failures++; $display("FAIL fault_drain2: got valid=%0b want 0", bus.inst_valid); end
    tick(1'b1, 1'b1, 1'b0, 1'b1, 32'h10, 1'b1);
    tick(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    tick(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    checks++; if (fault !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL fault_sticky: got fault=%0b busy=%0b want 1/0", fault, busy); end
    checks++; if (bus.imem_addr !== 32'h100 || fetch_count !== fc0 + 32'd2) begin
      failures++; $display("FAIL fault_frozen: got pc=%0h count=%0d want 100/%0d", bus.imem_addr, fetch_count, fc0 + 32'd2);
    end
  endtask

  task automatic test_halt();
    logic [31:0] frozen_pc, frozen_cnt, last_pc;
    tick(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    tick(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    for (int k = 0; k < 5; k++) tick(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    last_pc    = bus.inst_pc;
    frozen_pc  = bus.imem_addr;
    frozen_cnt = fetch_count;
    for (int k = 0; k < 3; k++) begin
      tick(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
      checks++; if (bus.imem_addr !== frozen_pc || fetch_count !== frozen_cnt || busy !== 1'b0) begin
        failures++; $display("FAIL halt_frozen%0d: got pc=%0h count=%0d busy=%0b want %0h/%0d/0", k, bus.imem_addr, fetch_count, busy, frozen_pc, frozen_cnt);
      end
    end
    tick(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL halt_resume_busy: got %0b want 1", busy); end
    for (int k = 1; k <= 3; k++) begin
      tick(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
      checks++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== last_pc + 32'(k)) begin
        failures++; $display("FAIL halt_resume%0d: got valid=%0b pc=%0h want 1/%0h", k, bus.inst_valid, bus.inst_pc, last_pc + 32'(k));
      end
    end
  endtask

  task automatic test_reset_midop();
    tick(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    tick(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    tick(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    tick(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    tick(1'b0, 1'b1, 1'b0, 1'b1, 32'h80, 1'b1);
    checks++; if (bus.inst_valid !== 1'b0 || bus.imem_addr !== RST_PC) begin
      failures++; $display("FAIL midrst_state: got valid=%0b pc=%0h want 0/%0h", bus.inst_valid, bus.imem_addr, RST_PC);
    end
    checks++; if (fetch_count !== 32'd0 || busy !== 1'b0 || fault !== 1'b0) begin
      failures++; $display("FAIL midrst_status: got count=%0d busy=%0b fault=%0b want 0/0/0", fetch_count, busy, fault);
    end
    tick(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    checks++; if (busy !== 1'b0 || bus.inst_valid !== 1'b0 || bus.imem_addr !== RST_PC) begin
      failures++; $display("FAIL midrst_idle: got busy=%0b valid=%0b pc=%0h want 0/0/%0h", busy, bus.inst_valid, bus.imem_addr, RST_PC);
    end
  endtask

  task automatic test_random();
    logic        rn, st, hr, rv, rdy;
    logic [31:0] rp;
    tick(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    for (int c = 0; c < 3000; c++) begin
      rn  = ($urandom_range(0, 99) != 0);
      st  = ($urandom_range(0, 1) == 0);
      hr  = ($urandom_range(0, 7) == 0);
      rv  = ($urandom_range(0, 11) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 3))
        0:       rp = 32'(MEM_WORDS) - 32'($urandom_range(1, 4));
        1:       rp = 32'(MEM_WORDS) + 32'($urandom_range(0, 3));
        default: rp = 32'($urandom_range(0, MEM_WORDS - 1));
      endcase
      tick(rn, st, hr, rv, rp, rdy);
      checks++; if (bus.inst_valid !== (m_q.size() > 0)) begin failures++; $display("FAIL rnd_valid@%0d: got %0b want %0b", c, bus.inst_valid, m_q.size() > 0); end
      if (m_q.size() > 0) begin
        checks++; if ({bus.inst_pc, bus.inst_out} !== m_q[0]) begin failures++; $display("FAIL rnd_head@%0d: got %0h want %0h", c, {bus.inst_pc, bus.inst_out}, m_q[0]); end
      end
      checks++; if (bus.imem_addr !== m_pc) begin failures++; $display("FAIL rnd_pc@%0d: got %0h want %0h", c, bus.imem_addr, m_pc); end
      checks++; if (fetch_count !== m_count) begin failures++; $display("FAIL rnd_count@%0d: got %0d want %0d", c, fetch_count, m_count); end
      checks++; if (busy !== (m_mode == M_RUN)) begin failures++; $display("FAIL rnd_busy@%0d: got %0b want %0b", c, busy, m_mode == M_RUN); end
      checks++; if (fault !== (m_mode == M_FAULT)) begin failures++; $display("FAIL rnd_fault@%0d: got %0b want %0b", c, fault, m_mode == M_FAULT); end
    end
  endtask

  initial begin
    rst_n              = 1'b0;
    start              = 1'b0;
    halt_req           = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.inst_ready     = 1'b0;
    m_mode             = M_IDLE;
    m_pc               = RST_PC;
    m_count            = 32'd0;
    #2;
    test_reset();
    test_sequential_fetch();
    test_backpressure();
    test_redirect();
    test_fault();
    test_halt();
    test_reset_midop();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
